uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//  Next-generation UART receiver: oversampled (OSR x) with 3-sample majority vote, runtime baud
//  divisor, optional parity, 1/2 stop bits, per-beat error flags and overrun/break detection.
//  Replaces the fixed-baud receiver between the rx CDC synchroniser and the rx FIFO in the uart top;
//  output is a valid/ready stream carrying data plus status.
// PARAMETERS
//  DLEN   8   data bits per frame (5..9)
//  OSR    16  oversample ticks per bit (even, >=8)
//  DIV_W  16  width of baud divisor input
// PORTS
//  clk          in   1       system clock
//  rstn         in   1       async active-low reset
//  i_rxs        in   1       rx line, already synchronised to clk (idle high)
//  i_div        in   DIV_W   clocks per oversample tick minus 1 (0 = tick every clk)
//  i_par_en     in   1       1 = parity bit present after data
//  i_par_odd    in   1       1 = odd parity, 0 = even
//  i_stop2      in   1       1 = two stop bits
//  o_tvalid     out  1       beat valid
//  i_tready     in   1       downstream ready
//  o_tdata      out  DLEN    received data, LSB first on line
//  o_perr       out  1       parity error on this beat (0 when parity disabled)
//  o_ferr       out  1       stop bit sampled low on this beat
//  o_break      out  1       break: data==0, parity (if en) 0, stop low
//  o_ovr        out  1       one-clk pulse: completed frame dropped, output still held
//  o_busy       out  1       FSM not in IDLE
// BEHAVIOUR
//  Clock: clk, single domain; reset: rstn, asynchronous, active-low.
//  - Reset: all outputs 0, FSM IDLE, counters 0; reset mid-frame abandons frame, no beat produced.
//  - Tick gen: counter 0..div_q, tick when ==div_q, then wraps to 0. div_q/par_en/par_odd/stop2
//    latched on start detect; changes mid-frame have no effect on the frame in progress.
//  - IDLE: start = i_rxs 0 with previous sample 1. On start: latch cfg, clear tick/sample counters -> START.
//  - Sampling: per bit, sample ctr 0..OSR-1 advances on tick; samples at OSR/2-1, OSR/2, OSR/2+1;
//    bit value = majority of the 3, decided on tick at OSR/2+1.
//  - START: majority 1 -> false start, back to IDLE, no beat. Else at ctr OSR-1 tick -> DATA.
//  - DATA: DLEN bits, shift in LSB first -> PARITY if par_en else STOP.
//  - PARITY: perr = (^data ^ bit) != par_odd.
//  - STOP: bit sampled at mid; any stop bit low sets ferr. With stop2, second stop bit also sampled.
//    Frame completes at mid-sample of last stop bit (no wait for bit end, allows resync).
//  - Completion: if !o_tvalid or (o_tvalid & i_tready) same cycle -> load tdata/flags, o_tvalid=1
//    next clk. Else frame dropped, o_ovr pulses 1 clk, held beat unchanged.
//  - Latency: o_tvalid rises 1 clk after last-stop mid decision.
//  - Handshake: beat held stable while o_tvalid & !i_tready; drops after transfer unless reloaded.
//  - Break: break=1 implies ferr=1. After any ferr, FSM -> WAIT_HI: start detect blocked until
//    i_rxs sampled high, then IDLE. Line held low yields exactly one beat.
//  - States: IDLE, START, DATA, PARITY, STOP, WAIT_HI (enum in package).
// STRUCTURE
//  - uart_pkg: rx_state_e enum; OSR default; uart_rx_status_t struct {perr, ferr, brk}.
//  - Sub-module uart_baud_tick (DIV_W): counter, i_clr, i_div -> o_tick; reusable by future uart_tx_os.
//  - Top: FSM, sample/bit counters, shift reg, majority voter, output register.
// TESTING  (DLEN=8, OSR=16, i_div=3 -> 64 clk/bit)
//  - 8N1 0xA5 -> one beat tdata=0xA5, perr=ferr=brk=0, tvalid ~9.5*64 clk after start edge.
//  - 8E1 0x5A parity 0 -> perr=0; same frame parity 1 -> tdata=0x5A, perr=1.
//  - Low glitch 20 clk -> no beat, busy drops, FSM IDLE; 1-clk glitch mid data bit -> data correct.
//  - Line low 12 bit times -> one beat tdata=0x00 ferr=1 brk=1; no second beat until line high.
//  - tready=0, send 0x11 then 0x22 -> tdata stays 0x11, o_ovr one pulse; tready=1 -> 0x11 out.
//  - rstn low mid-frame, then 8O2 0x3C -> outputs 0 during reset, then tdata=0x3C, flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the oversampled UART receiver and related blocks.
package uart_pkg;

   localparam int UART_OSR_DEF = 16;

   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_START   = 3'd1,
      RX_DATA    = 3'd2,
      RX_PARITY  = 3'd3,
      RX_STOP    = 3'd4,
      RX_WAIT_HI = 3'd5
   } rx_state_e;

   typedef struct packed {
      logic perr;
      logic ferr;
      logic brk;
   } uart_rx_status_t;

   // 2-of-3 majority used to reject single-sample line noise
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..i_div and pulses o_tick on the last count.
// Held at zero while i_clr is high so the first tick lands i_div+1 clocks after release.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_clr,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] cnt_q;

   assign o_tick = !i_clr && (cnt_q == i_div);

   // free-running divider, wraps after reaching the divisor
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (i_clr || (cnt_q == i_div)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with majority vote, runtime divisor, optional parity,
// 1/2 stop bits and a valid/ready output carrying data plus error status.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RX_IDLE    | waiting for a falling edge on the line
// RX_START   | validating start bit; majority high means false start
// RX_DATA    | shifting in DLEN data bits, LSB first
// RX_PARITY  | sampling the parity bit and evaluating parity error
// RX_STOP    | sampling stop bit(s); frame completes at mid of the last one
// RX_WAIT_HI | after a framing error, blocks start detect until line is high
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DLEN  = 8,
   parameter int OSR   = UART_OSR_DEF,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_rxs,
   input  logic [DIV_W-1:0] i_div,
   input  logic             i_par_en,
   input  logic             i_par_odd,
   input  logic             i_stop2,
   output logic             o_tvalid,
   input  logic             i_tready,
   output logic [DLEN-1:0]  o_tdata,
   output logic             o_perr,
   output logic             o_ferr,
   output logic             o_break,
   output logic             o_ovr,
   output logic             o_busy
);

   localparam int SCW = $clog2(OSR);
   localparam int BCW = $clog2(DLEN + 1);
   localparam logic [SCW-1:0] S_LO  = SCW'(OSR / 2 - 1);
   localparam logic [SCW-1:0] S_MID = SCW'(OSR / 2);
   localparam logic [SCW-1:0] S_HI  = SCW'(OSR / 2 + 1);
   localparam logic [SCW-1:0] S_END = SCW'(OSR - 1);
   localparam logic [BCW-1:0] B_LAST = BCW'(DLEN - 1);

   rx_state_e        state_q, state_d;
   logic             rxs_prev_q;
   logic [DIV_W-1:0] div_q;
   logic             par_en_q, par_odd_q, stop2_q;
   logic [SCW-1:0]   sctr_q;
   logic [BCW-1:0]   bctr_q;
   logic [1:0]       smp_q;
   logic [DLEN-1:0]  shreg_q;
   logic             perr_q, ferr_q, par_bit_q, stop_idx_q;

   logic             tvalid_q, ovr_q;
   logic [DLEN-1:0]  tdata_q;
   uart_rx_status_t  stat_q, stat_d;

   logic tick, tick_clr, start_det, in_frame;
   logic at_lo, at_mid, at_hi, at_end;
   logic bit_val, frame_done, ferr_final;

   assign tick_clr  = (state_q == RX_IDLE) || (state_q == RX_WAIT_HI);
   assign start_det = (state_q == RX_IDLE) && !i_rxs && rxs_prev_q;
   assign in_frame  = (state_q == RX_START) || (state_q == RX_DATA) ||
                      (state_q == RX_PARITY) || (state_q == RX_STOP);

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .clk    (clk),
      .rstn   (rstn),
      .i_clr  (tick_clr),
      .i_div  (div_q),
      .o_tick (tick)
   );

   assign at_lo   = tick && (sctr_q == S_LO);
   assign at_mid  = tick && (sctr_q == S_MID);
   assign at_hi   = tick && (sctr_q == S_HI);
   assign at_end  = tick && (sctr_q == S_END);
   assign bit_val = maj3(smp_q[0], smp_q[1], i_rxs);

   assign ferr_final = ferr_q || !bit_val;

   // FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; completion is flagged at the mid decision of the last stop bit
   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (start_det) state_d = RX_START;
         end
         RX_START: begin
            if (at_hi && bit_val) state_d = RX_IDLE;
            else if (at_end)      state_d = RX_DATA;
         end
         RX_DATA: begin
            if (at_end && (bctr_q == B_LAST)) state_d = par_en_q ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: begin
            if (at_end) state_d = RX_STOP;
         end
         RX_STOP: begin
            if (at_hi && (!stop2_q || stop_idx_q)) begin
               frame_done = 1'b1;
               state_d    = ferr_final ? RX_WAIT_HI : RX_IDLE;
            end
         end
         RX_WAIT_HI: begin
            if (i_rxs) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // sampling, counters, shift register and per-frame config/status
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rxs_prev_q <= 1'b0;
         div_q      <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop2_q    <= 1'b0;
         sctr_q     <= '0;
         bctr_q     <= '0;
         smp_q      <= '0;
         shreg_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         par_bit_q  <= 1'b0;
         stop_idx_q <= 1'b0;
      end else begin
         rxs_prev_q <= i_rxs;
         if (start_det) begin
            div_q      <= i_div;
            par_en_q   <= i_par_en;
            par_odd_q  <= i_par_odd;
            stop2_q    <= i_stop2;
            sctr_q     <= '0;
            bctr_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_idx_q <= 1'b0;
         end else if (in_frame && tick) begin
            if (at_lo)  smp_q[0] <= i_rxs;
            if (at_mid) smp_q[1] <= i_rxs;
            sctr_q <= at_end ? '0 : sctr_q + SCW'(1);
            if (at_hi) begin
               case (state_q)
                  RX_DATA:   shreg_q <= {bit_val, shreg_q[DLEN-1:1]};
                  RX_PARITY: begin
                     par_bit_q <= bit_val;
                     perr_q    <= ((^shreg_q) ^ bit_val) != par_odd_q;
                  end
                  RX_STOP:   if (!bit_val) ferr_q <= 1'b1;
                  default:   ;
               endcase
            end
            if (at_end) begin
               if (state_q == RX_DATA) bctr_q <= bctr_q + BCW'(1);
               if (state_q == RX_STOP) stop_idx_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      stat_d.perr = perr_q && par_en_q;
      stat_d.ferr = ferr_final;
      stat_d.brk  = (shreg_q == '0) && (!par_en_q || !par_bit_q) && ferr_final;
   end

   // output beat register: load when empty or draining, otherwise drop and flag overrun
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         stat_q   <= '0;
         ovr_q    <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         if (frame_done) begin
            if (!tvalid_q || i_tready) begin
               tvalid_q <= 1'b1;
               tdata_q  <= shreg_q;
               stat_q   <= stat_d;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (tvalid_q && i_tready) begin
            tvalid_q <= 1'b0;
         end
      end
   end

   assign o_tvalid = tvalid_q;
   assign o_tdata  = tdata_q;
   assign o_perr   = stat_q.perr;
   assign o_ferr   = stat_q.ferr;
   assign o_break  = stat_q.brk;
   assign o_ovr    = ovr_q;
   assign o_busy   = (state_q != RX_IDLE);

endmodule
